// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: PC/ROM fetch front end with skid-buffered valid/ready issue, branch redirect and halt drain
module fetch_issue_unit #(
  parameter int ADDR_W = 10,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [4:0] opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic instr_valid,
  input  logic instr_ready,
  input  logic branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic halted
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, instr_pc_q, instr_pc_d, skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d, skid_q, skid_d;
  logic pend_q, pend_d, valid_q, valid_d, skid_v_q, skid_v_d;
  logic run, take, out_free, is_halt, resp_ok;
  assign run = state_q == FETCH || state_q == DRAIN;
  assign take = valid_q && instr_ready;
  assign out_free = !valid_q || take;
  assign is_halt = pend_q && imem_rdata == HALT_WORD;
  assign resp_ok = pend_q && imem_rdata != HALT_WORD;
  assign imem_en = state_q == FETCH && (skid_v_q ? take : !(pend_q && !out_free));
  assign imem_addr = pc_q;
  assign instr = instr_q;
  assign opcode = instr_q[INSTR_W-1 -: 5];
  assign instr_pc = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted = state_q == HALT;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = 1'b0;
    req_pc_d = req_pc_q;
    instr_d = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d = valid_q;
    skid_d = skid_q;
    skid_pc_d = skid_pc_q;
    skid_v_d = skid_v_q;
    if (!run) begin
      state_d = start ? FETCH : state_q;
      pc_d = start ? RESET_PC : pc_q;
    end else if (branch_taken) begin
      state_d = FETCH;
      pc_d = branch_target;
      valid_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      pc_d = imem_en ? pc_q + ADDR_W'(1) : pc_q;
      pend_d = imem_en && !is_halt;
      req_pc_d = imem_en ? pc_q : req_pc_q;
      state_d = is_halt ? DRAIN : (state_q == DRAIN && !valid_q && !skid_v_q) ? HALT : state_q;
      if (out_free) begin
        valid_d = skid_v_q || resp_ok;
        instr_d = skid_v_q ? skid_q : resp_ok ? imem_rdata : instr_q;
        instr_pc_d = skid_v_q ? skid_pc_q : resp_ok ? req_pc_q : instr_pc_q;
        skid_v_d = 1'b0;
      end
      if (resp_ok && (!out_free || skid_v_q)) begin
        skid_d = imem_rdata;
        skid_pc_d = req_pc_q;
        skid_v_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      pend_q <= 1'b0;
      req_pc_q <= '0;
      instr_q <= '0;
      instr_pc_q <= '0;
      valid_q <= 1'b0;
      skid_q <= '0;
      skid_pc_q <= '0;
      skid_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      req_pc_q <= req_pc_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q <= valid_d;
      skid_q <= skid_d;
      skid_pc_q <= skid_pc_d;
      skid_v_q <= skid_v_d;
    end
  end
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: scoreboard bench with program-walk reference model and randomized ready/branch stimulus
module tb_fetch_issue_unit;
  localparam int AW = 10;
  localparam int IW = 32;
  logic clk = 0, rst = 1, start = 0, instr_ready = 0, branch_taken = 0;
  logic [AW-1:0] branch_target = '0;
  logic imem_en, instr_valid, halted;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [IW-1:0] imem_rdata = '0, instr;
  logic [4:0] opcode;
  logic [IW-1:0] rom [1024];
  logic [IW-1:0] rom2 [1024];
  logic w_start = 0, w_en, w_valid, w_halted;
  logic [AW-1:0] w_addr, w_pc;
  logic [IW-1:0] w_rdata = '0, w_instr;
  logic [4:0] w_op;
  int checks = 0, errors = 0, xfers = 0;
  int exp_q[$];
  int w_got[$];
  logic hv = 0;
  logic [IW-1:0] hi;
  logic [AW-1:0] hp;
  always #5 clk = ~clk;
  fetch_issue_unit dut (
    .clk(clk), .rst(rst), .start(start), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .halted(halted)
  );
  fetch_issue_unit #(.RESET_PC(10'h3FE)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .imem_en(w_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .instr(w_instr), .opcode(w_op), .instr_pc(w_pc),
    .instr_valid(w_valid), .instr_ready(1'b1), .branch_taken(1'b0),
    .branch_target(10'h000), .halted(w_halted)
  );
  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];
  always @(posedge clk) if (w_en) w_rdata <= rom2[w_addr];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_seg(input logic [AW-1:0] a);
    exp_q.delete();
    for (int n = 0; n < 1024 && rom[a] != 0; n++) begin
      exp_q.push_back(int'(a));
      a++;
    end
  endtask
  task automatic do_start(input logic [AW-1:0] pc0);
    start = 1;
    push_seg(pc0);
    step();
    start = 0;
  endtask
  task automatic wait_halt(input string name);
    for (int n = 0; n < 200 && !halted; n++) step();
    chk(name, halted, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask
  task automatic fill_rom(input int hpos);
    for (int i = 0; i < 128; i++) rom[i] = $urandom | 32'h1;
    rom[hpos] = '0;
  endtask
  task automatic run_random(input int hpos);
    for (int n = 0; n < 600 && !(halted && exp_q.size() == 0); n++) begin
      instr_ready = $urandom_range(0, 3) != 0;
      if (exp_q.size() > 0 && $urandom_range(0, 19) == 0) begin
        branch_taken = 1;
        branch_target = AW'($urandom_range(0, hpos - 1));
        push_seg(branch_target);
      end
      step();
      branch_taken = 0;
    end
    chk("rand_halted", halted, 1);
    chk("rand_drained", exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (hv) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, hi);
        chk("hold_pc", instr_pc, hp);
      end
      if (instr_valid && instr_ready && !branch_taken) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected actual pc %0h required none", instr_pc);
        end else begin
          int p;
          p = exp_q.pop_front();
          chk("xfer_pc", instr_pc, p);
          chk("xfer_instr", instr, rom[p]);
          chk("xfer_opcode", opcode, rom[p][31:27]);
        end
      end
      if (w_valid) w_got.push_back(int'(w_pc));
    end
    hv = !rst && instr_valid && !instr_ready && !branch_taken;
    hi = instr;
    hp = instr_pc;
  end
  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = $urandom | 32'h1;
      rom2[i] = $urandom | 32'h1;
    end
    rom[0] = 32'hA8000001;
    rom[1] = 32'hA8000002;
    rom[2] = 32'hA8000003;
    rom[3] = 32'h0;
    step(2);
    chk("rst_valid", instr_valid, 0);
    chk("rst_en", imem_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    rst = 0;
    instr_ready = 1;
    do_start(0);
    chk("lat_en", imem_en, 1);
    chk("lat_addr", imem_addr, 0);
    step();
    chk("lat_valid_e2", instr_valid, 0);
    step();
    chk("lat_valid_e3", instr_valid, 1);
    chk("lat_pc_e3", instr_pc, 0);
    step(3);
    chk("halt_e6", halted, 0);
    chk("valid_e6", instr_valid, 0);
    step();
    chk("halt_e7", halted, 1);
    chk("drained_e7", exp_q.size(), 0);
    instr_ready = 0;
    do_start(0);
    step(2);
    chk("bp_first_valid", instr_valid, 1);
    step(5);
    chk("bp_en_off", imem_en, 0);
    chk("bp_instr", instr, 32'hA8000001);
    chk("bp_pc", instr_pc, 0);
    instr_ready = 1;
    begin
      int x0;
      x0 = xfers;
      step(3);
      chk("bp_no_gap", xfers - x0, 3);
    end
    wait_halt("bp_halt");
    rom[3] = 32'hA8000004;
    rom[4] = 32'hA8000005;
    rom[5] = 32'h0;
    rom[10'h040] = 32'hA8000040;
    rom[10'h041] = 32'h0;
    do_start(0);
    for (int n = 0; n < 20 && !(instr_valid && instr_pc == 2); n++) step();
    instr_ready = 0;
    step(3);
    chk("br_held_pc", instr_pc, 2);
    chk("br_skid_full_en", imem_en, 0);
    branch_taken = 1;
    branch_target = 10'h040;
    push_seg(branch_target);
    instr_ready = 1;
    step();
    branch_taken = 0;
    chk("br_valid_flushed", instr_valid, 0);
    chk("br_en", imem_en, 1);
    chk("br_addr", imem_addr, 10'h040);
    wait_halt("br_halt");
    branch_taken = 1;
    branch_target = 10'h000;
    step();
    branch_taken = 0;
    step(2);
    chk("hbr_halted", halted, 1);
    chk("hbr_en", imem_en, 0);
    chk("hbr_valid", instr_valid, 0);
    do_start(0);
    chk("restart_halted", halted, 0);
    chk("restart_en", imem_en, 1);
    chk("restart_addr", imem_addr, 0);
    wait_halt("restart_halt");
    rom2[10'h3FE] = 32'hA80003FE;
    rom2[10'h3FF] = 32'hA80003FF;
    rom2[0] = 32'h0;
    w_start = 1;
    step();
    w_start = 0;
    for (int n = 0; n < 40 && !w_halted; n++) step();
    chk("wrap_halted", w_halted, 1);
    chk("wrap_count", w_got.size(), 2);
    chk("wrap_pc0", w_got.size() > 0 ? w_got[0] : -1, 10'h3FE);
    chk("wrap_pc1", w_got.size() > 1 ? w_got[1] : -1, 10'h3FF);
    fill_rom(30);
    instr_ready = 0;
    do_start(0);
    step(4);
    chk("mid_skid_full_en", imem_en, 0);
    rst = 1;
    exp_q.delete();
    step();
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_en", imem_en, 0);
    rst = 0;
    instr_ready = 1;
    step(4);
    chk("mid_no_stale", instr_valid, 0);
    chk("mid_idle_en", imem_en, 0);
    do_start(0);
    chk("mid_refetch_addr", imem_addr, 0);
    run_random(30);
    for (int t = 0; t < 15; t++) begin
      int h;
      h = $urandom_range(2, 60);
      fill_rom(h);
      do_start(0);
      run_random(h);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
